// File: rtl/piso_serializer_if.sv
// Handshake and serial-output bundle for piso_serializer.
// The producer and the serial consumer sit on the master side; the serializer sits on the slave side.
interface piso_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_i;
  logic             valid_i;
  logic             ready_o;
  logic             ser_o;
  logic             ser_valid_o;
  logic             last_o;

  modport slave (
    input  data_i, valid_i,
    output ready_o, ser_o, ser_valid_o, last_o
  );

  modport master (
    output data_i, valid_i,
    input  ready_o, ser_o, ser_valid_o, last_o
  );
endinterface

// File: rtl/piso_serializer.sv
// LSB-first parallel-in/serial-out transmitter with a valid/ready word input and gapless streaming.
// Optional feature: define PISO_PARITY_EN to append an even-parity bit after each word.
module piso_serializer #(
  parameter int WIDTH = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  piso_serializer_if.slave  bus
);

  localparam int                CNT_W     = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  LAST_DATA = CNT_W'(WIDTH - 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ready_q, ready_d;
  logic               ser_q, ser_d;
  logic               ser_valid_q, ser_valid_d;
  logic               last_q, last_d;
  logic               accept;
  logic               load;
`ifdef PISO_PARITY_EN
  logic               par_q, par_d;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      ser_q       <= 1'b0;
      ser_valid_q <= 1'b0;
      last_q      <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      ser_q       <= ser_d;
      ser_valid_q <= ser_valid_d;
      last_q      <= last_d;
`ifdef PISO_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
`ifdef PISO_PARITY_EN
    par_d   = par_q;
`endif
    accept  = bus.valid_i && ready_q;

    unique case (state_q)
      IDLE: load = accept;
      SHIFT: begin
        shift_d = shift_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_DATA) begin
`ifdef PISO_PARITY_EN
          state_d = PARITY;
`else
          if (accept) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
`endif
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        if (accept) begin
          load = 1'b1;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // A load overrides the frame-end path so the next word starts without a gap.
    if (load) begin
      state_d = SHIFT;
      shift_d = bus.data_i;
      cnt_d   = '0;
`ifdef PISO_PARITY_EN
      par_d   = ^bus.data_i;
`endif
    end

    // Outputs are computed from the next state and registered, keeping inputs off any output path.
    ser_valid_d = (state_d != IDLE);
    ser_d       = (state_d == SHIFT) ? shift_d[0] : 1'b0;
`ifdef PISO_PARITY_EN
    if (state_d == PARITY) ser_d = par_d;
    last_d      = (state_d == PARITY);
`else
    last_d      = (state_d == SHIFT) && (cnt_d == LAST_DATA);
`endif
    ready_d     = (state_d == IDLE) || last_d;
  end

  assign bus.ready_o     = ready_q;
  assign bus.ser_o       = ser_q;
  assign bus.ser_valid_o = ser_valid_q;
  assign bus.last_o      = last_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: each accepted word pushes its expected bit stream,
// and every falling edge pops and compares the serial outputs and ready_o.
module tb_piso_serializer;

  localparam int W = 8;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;

  piso_serializer_if #(.WIDTH(W)) pif ();

  piso_serializer #(.WIDTH(W)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (pif.slave)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  logic exp_rdy;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   edges_since_rst = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_word(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) begin
`ifdef PISO_PARITY_EN
      sb.push_back('{b: w[i], last: 1'b0});
`else
      sb.push_back('{b: w[i], last: (i == W - 1)});
`endif
    end
`ifdef PISO_PARITY_EN
    sb.push_back('{b: ^w, last: 1'b1});
`endif
  endtask

  // Counts rising edges since reset release; ready_o may only be high after the first one.
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) edges_since_rst <= 0;
    else if (edges_since_rst < 2) edges_since_rst <= edges_since_rst + 1;
  end

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      check("rst_ready", pif.ready_o, 1'b0);
      check("rst_ser", pif.ser_o, 1'b0);
      check("rst_ser_valid", pif.ser_valid_o, 1'b0);
      check("rst_last", pif.last_o, 1'b0);
      sb.delete();
    end else begin
      if (sb.size() > 0) begin
        cur = sb.pop_front();
        check("ser_valid", pif.ser_valid_o, 1'b1);
        check("ser", pif.ser_o, cur.b);
        check("last", pif.last_o, cur.last);
        check("ready_busy", pif.ready_o, cur.last);
        exp_rdy = cur.last;
      end else begin
        exp_rdy = (edges_since_rst > 0);
        check("idle_ser_valid", pif.ser_valid_o, 1'b0);
        check("idle_last", pif.last_o, 1'b0);
        check("idle_ready", pif.ready_o, exp_rdy);
      end
      if (pif.valid_i && exp_rdy) push_word(pif.data_i);
    end
  end

  // Presents a word with valid high until ready is seen, then returns just after the accepting edge.
  task automatic send(input logic [W-1:0] w);
    pif.data_i  = w;
    pif.valid_i = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk_i);
      if (pif.ready_o) begin
        @(posedge clk_i);
        #1;
        return;
      end
    end
    check("send_ready_timeout", pif.ready_o, 1'b1);
  endtask

  task automatic idle(input int n);
    pif.valid_i = 1'b0;
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  initial begin
    // Reset held with a word on offer: nothing may be accepted or emitted.
    pif.data_i  = 8'h55;
    pif.valid_i = 1'b1;
    repeat (5) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    pif.valid_i = 1'b0;
    idle(3);

    // Single word.
    send(8'hA5);
    idle(12);

    // Back-to-back with valid held high.
    send(8'h01);
    send(8'h80);
    idle(20);

    // Busy stall: data changes mid-frame are ignored, next word taken on the last bit.
    send(8'hFF);
    for (int i = 0; i < 3; i++) begin
      pif.data_i = 8'($urandom);
      @(posedge clk_i);
      #1;
    end
    send(8'h00);
    idle(12);

    // Reset mid-frame.
    send(8'h3C);
    repeat (4) @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    check("abort_ready", pif.ready_o, 1'b0);
    check("abort_ser", pif.ser_o, 1'b0);
    check("abort_ser_valid", pif.ser_valid_o, 1'b0);
    check("abort_last", pif.last_o, 1'b0);
    pif.valid_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    idle(5);

    // Parity-relevant words and a short random stream with gaps.
    send(8'h07);
    send(8'h03);
    idle(12);
    for (int i = 0; i < 8; i++) begin
      send(8'($urandom));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 4));
    end
    idle(14);

    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out transmitter for the basic_blocks library. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out LSB-first, one bit per clock, with a serial-valid qualifier and a last-bit marker. It is the sending end of the team's single-bit serial datapath and drives a matching deserializer or a resettable flip-flop capture stage downstream. Back-to-back words stream with no idle gap.

## Interface
- WIDTH, 8, data word width in bits; legal range ≥ 2
- clk_i  input  1  clock; all state updates on rising edge
- rst_ni  input  1  reset, asynchronous, active-low
- data_i  input  WIDTH  parallel word; sampled only on an accepted handshake
- valid_i  input  1  producer has a word on data_i
- ready_o  output  1  block can accept a word this cycle
- ser_o  output  1  current serial bit
- ser_valid_o  output  1  ser_o carries a frame bit this cycle
- last_o  output  1  ser_o is the final bit of the frame

## Operation
- Reset (rst_ni low, takes effect immediately): state = IDLE; ready_o = 0, ser_o = 0, ser_valid_o = 0, last_o = 0; shift register and bit counter cleared.
- All outputs are registered. ready_o rises at the first rising edge with rst_ni high.
- Accept: on a rising edge with valid_i && ready_o, load data_i into the shift register, clear the bit counter, and enter SHIFT.
- States:
  - IDLE: ser_valid_o = 0, ready_o = 1. Goes to SHIFT on accept.
  - SHIFT: ser_o = shift_reg[0], ser_valid_o = 1. Each edge shifts right by one and increments the counter.
  - PARITY: present only with the macro; see Configuration.
- Frame length F = WIDTH bits (WIDTH+1 with parity). The counter is $clog2(WIDTH+1) bits and never exceeds F-1.
- last_o = 1 exactly on bit F-1.
- ready_o = 1 during the last-bit cycle, which allows a gapless follow-on word.
- End of frame, on the edge that ends the last bit:
  - Accept happening: load the new word and start its bit 0 the next cycle.
  - No accept: go to IDLE with ser_valid_o = 0.
- Outside the last-bit cycle of SHIFT/PARITY, ready_o = 0. valid_i and data_i are ignored, and changing data_i mid-frame has no effect.
- The producer may drop valid_i without a handshake. No protocol error is flagged.
- Reset asserted mid-frame aborts the frame immediately. There is no partial output after release.

## Timing
- Latency: word accepted at edge N, so bit 0 is on ser_o during cycle N+1 (after edge N). Bit k is at cycle N+1+k.
- Throughput: one word per F cycles when valid_i is held high. ser_valid_o stays continuously high across words.
- Idle-to-accept: in IDLE, ready_o is already high, so an accept happens on the same edge valid_i is seen.
- No combinational path from any input to any output.

## Configuration
- PISO_PARITY_EN defined:
  - At accept, compute even parity p = ^data_i and store it.
  - After bit WIDTH-1, enter PARITY for one cycle: ser_o = p, ser_valid_o = 1, last_o = 1.
  - In this mode last_o is not asserted on bit WIDTH-1, and ready_o is high in the PARITY cycle instead.
  - F = WIDTH+1.
- PISO_PARITY_EN undefined: no PARITY state, no parity register, F = WIDTH. The interface is identical in both builds.

## Test plan
- Single word: WIDTH=8, pulse valid_i with data_i=8'hA5 → ser_o = 1,0,1,0,0,1,0,1 over 8 consecutive cycles, ser_valid_o high for exactly those 8, last_o high only on the 8th, then IDLE with ready_o=1.
- Back-to-back: hold valid_i, present 8'h01 then 8'h80 → 16 gapless ser_valid_o cycles, ser_o = 1,0×7,0×7,1, last_o pulses on cycles 8 and 16, second accept occurs on the edge ending the first frame's last bit.
- Busy stall: accept 8'hFF, then toggle data_i=8'h00 with valid_i high mid-frame → ser_o stays all-ones for 8 bits. The second word is accepted only during the last-bit cycle.
- Reset mid-frame: accept 8'h3C, assert rst_ni low after bit 3 → all outputs 0 immediately. After release, ready_o=1 on the first edge and ser_valid_o stays low until a new accept.
- Parity (PISO_PARITY_EN): data_i=8'h07 → 8 data bits, then ser_o=1 with last_o high on cycle 9. data_i=8'h03 → 9th bit 0.
- Reset values: hold rst_ni low for 5 cycles with valid_i high → ready_o, ser_valid_o, last_o, ser_o all 0 throughout and no word accepted.
